// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and defaults for the predictor table update scheduler.
// Contents: FSM state encoding, resolution record layout, default parameters.
package bp_update_scheduler_pkg;

    localparam int unsigned DEPTH_DEF      = 4;
    localparam int unsigned IDX_W_DEF      = 6;
    localparam int unsigned STARVE_MAX_DEF = 8;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    // One resolved branch, 67 bits: {pc, taken, target, pred}
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  pred;
    } res_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Bus between MEM resolution logic / fetch and the update scheduler.
// master: resolution producer and fetch side; slave: the scheduler.
// Optional Stat_* signals exist only when BP_UPD_STATS_EN is defined.
interface bp_update_scheduler_if #(
    parameter int unsigned IDX_W = 6
);
    logic             Res_valid;
    logic [31:0]      Res_pc;
    logic             Res_taken;
    logic [31:0]      Res_target;
    logic [1:0]       Res_pred;
    logic             Lookup_req;
    logic             Upd_valid;
    logic             Upd_clear;
    logic [IDX_W-1:0] Upd_index;
    logic [31:0]      Upd_pc;
    logic             Upd_taken;
    logic [31:0]      Upd_target;
    logic [1:0]       Upd_pred;
    logic             Stall_fetch;
    logic             Ready;
    logic             Full;
`ifdef BP_UPD_STATS_EN
    logic [15:0]      Stat_drops;
    logic [15:0]      Stat_forced;
`endif

    modport master (
        output Res_valid, Res_pc, Res_taken, Res_target, Res_pred, Lookup_req,
        input  Upd_valid, Upd_clear, Upd_index, Upd_pc, Upd_taken, Upd_target,
        input  Upd_pred, Stall_fetch, Ready, Full
`ifdef BP_UPD_STATS_EN
        , input Stat_drops, Stat_forced
`endif
    );

    modport slave (
        input  Res_valid, Res_pc, Res_taken, Res_target, Res_pred, Lookup_req,
        output Upd_valid, Upd_clear, Upd_index, Upd_pc, Upd_taken, Upd_target,
        output Upd_pred, Stall_fetch, Ready, Full
`ifdef BP_UPD_STATS_EN
        , output Stat_drops, Stat_forced
`endif
    );

endinterface

// File: rtl/bp_res_fifo.sv
// In-order resolution FIFO, DEPTH x res_t.
// Ports: CLK, RESET (async active-low), push/din, pop, head (current head
// entry), full, empty (both registered). A push while full is dropped unless
// a pop happens on the same edge. No bypass: a pushed entry is visible only
// after the edge that stores it.
module bp_res_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic push,
    input  res_t din,
    input  logic pop,
    output res_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;
    res_t          mem_q [DEPTH];
    res_t          mem_d [DEPTH];

    // Pointer/storage update; pointers carry one extra wrap bit
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            mem_q    <= mem_d;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences all writes into the shared predictor-table write port.
// After reset it sweeps every index with a clear write, then issues queued
// branch resolutions in cycles where fetch is not reading, forcing an issue
// (and stalling fetch) after STARVE_MAX blocked cycles.
// Ports: CLK, RESET (async active-low), bus (slave modport of
// bp_update_scheduler_if). All bus outputs are registered.
// Build option BP_UPD_STATS_EN adds Stat_drops / Stat_forced counters.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bp_update_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_clear_q, upd_clear_d;
    logic [IDX_W-1:0] upd_index_q, upd_index_d;
    res_t             upd_res_q, upd_res_d;
    logic             stall_q, stall_d;
    logic             ready_q, ready_d;
    logic             pop, forced;
    logic             fifo_full, fifo_empty;
    res_t             res_in, head;

    assign res_in = {bus.Res_pc, bus.Res_taken, bus.Res_target, bus.Res_pred};

    bp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (bus.Res_valid),
        .din   (res_in),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state, sweep/starvation counters and next output values
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        starve_d    = starve_q;
        upd_valid_d = 1'b0;
        upd_clear_d = 1'b0;
        upd_index_d = '0;
        upd_res_d   = '0;
        stall_d     = 1'b0;
        ready_d     = 1'b0;
        pop         = 1'b0;
        forced      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                upd_valid_d = 1'b1;
                upd_clear_d = 1'b1;
                upd_index_d = sweep_q;
                sweep_d     = sweep_q + IDX_W'(1);
                if (sweep_q == {IDX_W{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ready_d = 1'b1;
                forced  = (starve_q == CNT_W'(STARVE_MAX));
                if (fifo_empty) begin
                    starve_d = '0;
                end else if (!bus.Lookup_req || forced) begin
                    pop         = 1'b1;
                    upd_valid_d = 1'b1;
                    upd_index_d = head.pc[IDX_W+1:2];
                    upd_res_d   = head;
                    stall_d     = forced;
                    starve_d    = '0;
                end else begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_CLEAR;
            sweep_q     <= '0;
            starve_q    <= '0;
            upd_valid_q <= 1'b0;
            upd_clear_q <= 1'b0;
            upd_index_q <= '0;
            upd_res_q   <= '0;
            stall_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            starve_q    <= starve_d;
            upd_valid_q <= upd_valid_d;
            upd_clear_q <= upd_clear_d;
            upd_index_q <= upd_index_d;
            upd_res_q   <= upd_res_d;
            stall_q     <= stall_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.Upd_valid   = upd_valid_q;
    assign bus.Upd_clear   = upd_clear_q;
    assign bus.Upd_index   = upd_index_q;
    assign bus.Upd_pc      = upd_res_q.pc;
    assign bus.Upd_taken   = upd_res_q.taken;
    assign bus.Upd_target  = upd_res_q.target;
    assign bus.Upd_pred    = upd_res_q.pred;
    assign bus.Stall_fetch = stall_q;
    assign bus.Ready       = ready_q;
    assign bus.Full        = fifo_full;

`ifdef BP_UPD_STATS_EN
    logic [15:0] stat_drops_q, stat_drops_d;
    logic [15:0] stat_forced_q, stat_forced_d;
    logic        drop;

    // Saturating event counters; a drop is a push refused by a full FIFO
    always_comb begin
        drop          = bus.Res_valid && fifo_full && !pop;
        stat_drops_d  = stat_drops_q;
        stat_forced_d = stat_forced_q;
        if (drop && (stat_drops_q != 16'hFFFF)) begin
            stat_drops_d = stat_drops_q + 16'd1;
        end
        if (pop && forced && (stat_forced_q != 16'hFFFF)) begin
            stat_forced_d = stat_forced_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_drops_q  <= '0;
            stat_forced_q <= '0;
        end else begin
            stat_drops_q  <= stat_drops_d;
            stat_forced_q <= stat_forced_d;
        end
    end

    assign bus.Stat_drops  = stat_drops_q;
    assign bus.Stat_forced = stat_forced_q;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bp_update_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bp_update_scheduler_if #(.IDX_W(6)) bus ();

    bp_update_scheduler #(
        .DEPTH      (4),
        .IDX_W      (6),
        .STARVE_MAX (8)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic [1:0] pr);
        bus.Res_valid  = 1'b1;
        bus.Res_pc     = pc;
        bus.Res_taken  = tk;
        bus.Res_target = tgt;
        bus.Res_pred   = pr;
    endtask

    task automatic idle_res();
        bus.Res_valid  = 1'b0;
        bus.Res_pc     = 32'h0;
        bus.Res_taken  = 1'b0;
        bus.Res_target = 32'h0;
        bus.Res_pred   = 2'b00;
    endtask

    // Expect one issued (non-clear) update of the given PC
    task automatic expect_issue(input string tag, input logic [31:0] pc, input logic stall);
        logic [31:0] idx;
        idx = {26'd0, pc[7:2]};
        check({tag, "_valid"}, 32'(bus.Upd_valid), 32'd1);
        check({tag, "_clear"}, 32'(bus.Upd_clear), 32'd0);
        check({tag, "_pc"},    bus.Upd_pc, pc);
        check({tag, "_index"}, 32'(bus.Upd_index), idx);
        check({tag, "_stall"}, 32'(bus.Stall_fetch), 32'(stall));
    endtask

    task automatic expect_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.Upd_valid), 32'd0);
        check({tag, "_clear"}, 32'(bus.Upd_clear), 32'd0);
        check({tag, "_index"}, 32'(bus.Upd_index), 32'd0);
        check({tag, "_pc"},    bus.Upd_pc, 32'd0);
        check({tag, "_stall"}, 32'(bus.Stall_fetch), 32'd0);
        check({tag, "_ready"}, 32'(bus.Ready), 32'd0);
        check({tag, "_full"},  32'(bus.Full), 32'd0);
`ifdef BP_UPD_STATS_EN
        check({tag, "_sdrops"},  32'(bus.Stat_drops), 32'd0);
        check({tag, "_sforced"}, 32'(bus.Stat_forced), 32'd0);
`endif
    endtask

    logic [31:0] pcs [5];

    initial begin
        rst_n = 1'b0;
        bus.Lookup_req = 1'b0;
        idle_res();
        tick();
        tick();
        expect_outputs_zero("rst");

        // 1: clear sweep then idle
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            check("sweep_valid", 32'(bus.Upd_valid), 32'd1);
            check("sweep_clear", 32'(bus.Upd_clear), 32'd1);
            check("sweep_index", 32'(bus.Upd_index), 32'(i));
            check("sweep_ready", 32'(bus.Ready), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 32'(bus.Ready), 32'd1);
            check("idle_valid", 32'(bus.Upd_valid), 32'd0);
            check("idle_clear", 32'(bus.Upd_clear), 32'd0);
        end

        // 2: single resolution, free port
        drive_res(32'h0040_0010, 1'b1, 32'h0040_1234, 2'b10);
        tick();
        idle_res();
        check("t2_nobypass", 32'(bus.Upd_valid), 32'd0);
        tick();
        expect_issue("t2", 32'h0040_0010, 1'b0);
        check("t2_idx4", 32'(bus.Upd_index), 32'h04);
        check("t2_target", bus.Upd_target, 32'h0040_1234);
        check("t2_taken", 32'(bus.Upd_taken), 32'd1);
        check("t2_pred", 32'(bus.Upd_pred), 32'd2);
        tick();
        check("t2_after", 32'(bus.Upd_valid), 32'd0);

        // 3: starvation forces issue on the 9th blocked cycle
        bus.Lookup_req = 1'b1;
        drive_res(32'h0040_0020, 1'b0, 32'h0000_0abc, 2'b01);
        tick();
        idle_res();
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_blocked", 32'(bus.Upd_valid), 32'd0);
        end
        tick();
        expect_issue("t3", 32'h0040_0020, 1'b1);
        check("t3_taken", 32'(bus.Upd_taken), 32'd0);
        check("t3_pred", 32'(bus.Upd_pred), 32'd1);
        tick();
        check("t3_after_valid", 32'(bus.Upd_valid), 32'd0);
        check("t3_after_stall", 32'(bus.Stall_fetch), 32'd0);
`ifdef BP_UPD_STATS_EN
        check("t3_sforced", 32'(bus.Stat_forced), 32'd1);
`endif

        // 4: fill, drop the 5th, drain in order
        pcs[0] = 32'h0000_0204; pcs[1] = 32'h0000_0308; pcs[2] = 32'h0000_040C;
        pcs[3] = 32'h0000_0510; pcs[4] = 32'h0000_0614;
        for (int i = 0; i < 4; i++) begin
            check("t4_notfull", 32'(bus.Full), 32'd0);
            drive_res(pcs[i], i[0], pcs[i] + 32'h100, 2'(i));
            tick();
        end
        check("t4_full", 32'(bus.Full), 32'd1);
        drive_res(pcs[4], 1'b1, 32'h0, 2'b11);
        tick();
        idle_res();
        bus.Lookup_req = 1'b0;
        check("t4_full_after_drop", 32'(bus.Full), 32'd1);
        check("t4_blocked", 32'(bus.Upd_valid), 32'd0);
`ifdef BP_UPD_STATS_EN
        check("t4_sdrops", 32'(bus.Stat_drops), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_issue("t4", pcs[i], 1'b0);
            check("t4_target", bus.Upd_target, pcs[i] + 32'h100);
            check("t4_fullflag", 32'(bus.Full), 32'd0);
        end
        tick();
        check("t4_drained", 32'(bus.Upd_valid), 32'd0);

        // 5: push and pop on the same edge while full
        bus.Lookup_req = 1'b1;
        for (int i = 0; i < 5; i++) pcs[i] = 32'h0000_1000 + 32'(4 * i);
        for (int i = 0; i < 4; i++) begin
            drive_res(pcs[i], 1'b0, 32'h0, 2'b00);
            tick();
        end
        check("t5_full", 32'(bus.Full), 32'd1);
        bus.Lookup_req = 1'b0;
        drive_res(pcs[4], 1'b1, 32'h0000_2000, 2'b00);
        tick();
        idle_res();
        expect_issue("t5_first", pcs[0], 1'b0);
        check("t5_still_full", 32'(bus.Full), 32'd1);
        for (int i = 1; i < 5; i++) begin
            tick();
            expect_issue("t5", pcs[i], 1'b0);
        end
        check("t5_last_target", bus.Upd_target, 32'h0000_2000);
        tick();
        check("t5_drained", 32'(bus.Upd_valid), 32'd0);
`ifdef BP_UPD_STATS_EN
        check("t5_sdrops", 32'(bus.Stat_drops), 32'd1);
`endif

        // 6: reset mid-sweep at index 30
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            tick();
            check("t6_sweep_index", 32'(bus.Upd_index), 32'(i));
        end
        rst_n = 1'b0;
        #1;
        expect_outputs_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart_valid", 32'(bus.Upd_valid), 32'd1);
        check("t6_restart_clear", 32'(bus.Upd_clear), 32'd1);
        check("t6_restart_index", 32'(bus.Upd_index), 32'd0);
        tick();
        check("t6_restart_index1", 32'(bus.Upd_index), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
